imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Elastic, parametrised immediate generator for the pipelined core. It extends the single-cycle immediate generator in four ways: XLEN-wide sign extension, two extra formats (CSR zimm and shift amount), an AUTO mode that derives the format from the opcode, and a PIPE_DEPTH-stage valid/ready register pipeline carrying a caller tag (typically the PC). It sits between fetch/decode and the execute operand mux.

## Interface
Parameters:
- XLEN, 32: immediate/output width; 32 or 64 only.
- PIPE_DEPTH, 1: number of register stages, 1..4.
- TAG_W, 32: width of the pass-through tag.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_valid  in  1  input instruction valid.
- o_ready  out  1  stage 0 can accept this cycle.
- i_inst  in  32  instruction word.
- i_immsel  in  3  format select. Encodings: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z, 110 SH, 111 AUTO.
- i_tag  in  TAG_W  opaque sideband, returned unchanged.
- o_valid  out  1  output stage holds data.
- i_ready  in  1  consumer accepts.
- o_imm  out  XLEN  immediate.
- o_fmt  out  3  resolved format; never 111.
- o_noimm  out  1  AUTO mode found no immediate; o_imm = 0.
- o_tag  out  TAG_W  tag of the output entry.

## Operation
- Computation is combinational on the input side of stage 0. Later stages only carry registered data.
- Formats. Bit 31 fills all upper bits up to XLEN-1 unless stated otherwise.
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - U: {inst[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - Z: inst[19:15], zero-extended.
  - SH: inst[24:20] when XLEN=32, inst[25:20] when XLEN=64, zero-extended.
- AUTO resolution by opcode inst[6:0]:
  - 0000011 LOAD → I.
  - 1100111 JALR → I.
  - 0010011 OP-IMM → SH if funct3 ∈ {001, 101}, else I.
  - 1110011 SYSTEM → Z if funct3[2]=1, else I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111 and 0010111 → U.
  - Anything else → o_fmt=I, o_noimm=1, o_imm=0.
- Explicit selects never set o_noimm and ignore the opcode.
- Elastic pipeline:
  - Each stage k has a valid bit v[k].
  - Stage k loads when it is empty or stage k+1 (or the consumer, for the last stage) takes its entry in the same cycle.
  - o_ready = ~v[0] | stage 0 advancing. Bubbles collapse: a stalled output does not block stages that hold bubbles.
  - Transfer on input: i_valid & o_ready. Transfer on output: o_valid & i_ready.
  - Data registers capture only on their stage's load enable. Held entries stay stable while o_valid & ~i_ready.
- Entries are never dropped, duplicated or reordered.

## Timing
- Latency: PIPE_DEPTH cycles from input transfer to o_valid, with no stall.
- Throughput: 1 per cycle under continuous i_ready.
- Capacity: PIPE_DEPTH entries. With i_ready low, o_ready falls once all stages are valid. o_ready depends combinationally on i_ready.
- Simultaneous input and output transfer on a full pipe: legal. Occupancy stays unchanged.
- Reset (i_rst_n=0 at an edge), including mid-stream:
  - All v[k] ← 0.
  - o_imm, o_fmt, o_noimm and o_tag ← 0.
  - In-flight entries are discarded.
  - o_ready is 1 in the first cycle after reset is released.
- No combinational path from i_inst to o_imm.

## Structure
- Package imm_pkg holds:
  - immsel_e enum (I, S, B, J, U, Z, SH, AUTO).
  - Opcode constants OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC.
  - A struct imm_entry_t {imm, fmt, noimm, tag}.
- Sub-module imm_pipe_stage: one elastic register stage over imm_entry_t, instantiated PIPE_DEPTH times by a generate loop. Format decode stays in the top level.

## Test plan
- AUTO, XLEN=32, 0xFFF00093 (addi x1,x0,-1) → o_imm=0xFFFFFFFF, o_fmt=I, o_noimm=0. Then 0x00112623 (sw) → 12, S. Then 0xFFDFF06F (jal -4) → 0xFFFFFFFC, J. Then 0x123452B7 (lui) → 0x12345000, U.
- AUTO with 0x3002D073 (csrrwi, zimm 5) → 5, fmt Z. AUTO with 0x00309093 (slli x1,3) → 3, fmt SH. AUTO with 0x002081B3 (add) → o_noimm=1, o_imm=0.
- XLEN=64, explicit U, 0x800000B7 → 0xFFFFFFFF80000000. Explicit SH with inst[25:20]=0x3F → 63.
- PIPE_DEPTH=2, continuous i_valid with tags 1,2,3,…, i_ready low for cycles 3–5:
  - o_ready drops once 2 entries are held.
  - Tags emerge in order, with no loss or duplication.
  - Held output stays stable while stalled.
- PIPE_DEPTH=3, one bubble between two entries, output stalled → the bubble collapses and o_ready stays 1 until 3 entries are held.
- Reset asserted for one cycle with 2 entries in flight → o_valid=0 and all outputs 0 on the next cycle. Next accepted entry emerges after PIPE_DEPTH cycles.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// The entry struct is sized for the widest configuration; unused upper bits are tied to zero.
package imm_pkg;

    typedef enum logic [2:0] {
        SEL_I    = 3'b000,
        SEL_S    = 3'b001,
        SEL_B    = 3'b010,
        SEL_J    = 3'b011,
        SEL_U    = 3'b100,
        SEL_Z    = 3'b101,
        SEL_SH   = 3'b110,
        SEL_AUTO = 3'b111
    } immsel_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 64;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        immsel_e              fmt;
        logic                 noimm;
        logic [TAG_MAX_W-1:0] tag;
    } imm_entry_t;

endpackage

// File: rtl/imm_pipe_stage.sv
// One elastic valid/ready register stage carrying an imm_entry_t.
// Loads whenever empty or when its current entry is taken downstream in the same cycle.
module imm_pipe_stage
    import imm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up_valid,
    output logic       up_ready,
    input  imm_entry_t up_data,
    output logic       dn_valid,
    input  logic       dn_ready,
    output imm_entry_t dn_data
);

    logic       valid_q, valid_d;
    imm_entry_t data_q, data_d;
    logic       load;

    // A bubble never blocks: an empty stage loads regardless of dn_ready.
    always_comb begin
        load    = ~valid_q | dn_ready;
        valid_d = load ? up_valid : valid_q;
        data_d  = load ? up_data  : data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign up_ready = load;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with AUTO format resolution feeding a PIPE_DEPTH-stage elastic pipeline.
// Decode is purely combinational ahead of stage 0; TAG_W must not exceed 64.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PIPE_DEPTH = 1,
    parameter int TAG_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [2:0]       i_immsel,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic             o_noimm,
    output logic [TAG_W-1:0] o_tag
);

    logic [6:0]  opc;
    logic [2:0]  funct3;
    immsel_e     fmt_res;
    logic        noimm;
    logic [63:0] imm64;
    imm_entry_t  in_e;

    assign opc    = i_inst[6:0];
    assign funct3 = i_inst[14:12];

    always_comb begin
        fmt_res = immsel_e'(i_immsel);
        noimm   = 1'b0;
        if (immsel_e'(i_immsel) == SEL_AUTO) begin
            unique case (opc)
                OPC_LOAD, OPC_JALR: fmt_res = SEL_I;
                OPC_OPIMM: begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) fmt_res = SEL_SH;
                    else                                      fmt_res = SEL_I;
                end
                OPC_SYSTEM: begin
                    if (funct3[2]) fmt_res = SEL_Z;
                    else           fmt_res = SEL_I;
                end
                OPC_STORE:         fmt_res = SEL_S;
                OPC_BRANCH:        fmt_res = SEL_B;
                OPC_JAL:           fmt_res = SEL_J;
                OPC_LUI, OPC_AUIPC: fmt_res = SEL_U;
                default: begin
                    fmt_res = SEL_I;
                    noimm   = 1'b1;
                end
            endcase
        end
    end

    // Values are built 64 bits wide and truncated afterwards, so a single
    // sign-extension path serves both XLEN settings.
    always_comb begin
        imm64 = '0;
        unique case (fmt_res)
            SEL_I:  imm64 = {{52{i_inst[31]}}, i_inst[31:20]};
            SEL_S:  imm64 = {{52{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            SEL_B:  imm64 = {{51{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                             i_inst[11:8], 1'b0};
            SEL_J:  imm64 = {{43{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                             i_inst[30:21], 1'b0};
            SEL_U:  imm64 = {{32{i_inst[31]}}, i_inst[31:12], 12'b0};
            SEL_Z:  imm64 = {59'b0, i_inst[19:15]};
            SEL_SH: begin
                if (XLEN == 64) imm64 = {58'b0, i_inst[25:20]};
                else            imm64 = {59'b0, i_inst[24:20]};
            end
            default: imm64 = '0;
        endcase
        if (noimm) imm64 = '0;
    end

    always_comb begin
        in_e       = '0;
        in_e.imm   = (XLEN == 64) ? imm64 : {32'b0, imm64[31:0]};
        in_e.fmt   = fmt_res;
        in_e.noimm = noimm;
        in_e.tag   = TAG_MAX_W'(i_tag);
    end

    logic [PIPE_DEPTH:0] vld_pipe;
    logic [PIPE_DEPTH:0] rdy_pipe;
    imm_entry_t          dat_pipe [PIPE_DEPTH+1];

    assign vld_pipe[0]          = i_valid;
    assign dat_pipe[0]          = in_e;
    assign rdy_pipe[PIPE_DEPTH] = i_ready;

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        imm_pipe_stage u_stage (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .up_valid (vld_pipe[k]),
            .up_ready (rdy_pipe[k]),
            .up_data  (dat_pipe[k]),
            .dn_valid (vld_pipe[k+1]),
            .dn_ready (rdy_pipe[k+1]),
            .dn_data  (dat_pipe[k+1])
        );
    end

    imm_entry_t out_e;
    logic       unused_bits;

    assign out_e       = dat_pipe[PIPE_DEPTH];
    assign o_ready     = rdy_pipe[0];
    assign o_valid     = vld_pipe[PIPE_DEPTH];
    assign o_imm       = out_e.imm[XLEN-1:0];
    assign o_fmt       = out_e.fmt;
    assign o_noimm     = out_e.noimm;
    assign o_tag       = out_e.tag[TAG_W-1:0];
    assign unused_bits = ^{out_e.imm, out_e.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: two configurations (XLEN=32/depth 2, XLEN=64/depth 3),
// each with its own driver pushing expected entries and a monitor popping on output transfers.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        noimm;
        logic [31:0] tag;
        int          t_in;
        bit          exact;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: resolve the format from the opcode table, then take the field value
    // as a signed (or unsigned) integer and truncate to the datapath width.
    function automatic void model(input int xl, input logic [31:0] ins, input logic [2:0] sel,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic nimm);
        logic [6:0] op;
        logic [2:0] f3;
        longint     v;
        op   = ins[6:0];
        f3   = ins[14:12];
        fmt  = sel;
        nimm = 1'b0;
        if (sel == 3'd7) begin
            case (op)
                7'h03, 7'h67: fmt = 3'd0;
                7'h13:        fmt = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd0;
                7'h73:        fmt = f3[2] ? 3'd5 : 3'd0;
                7'h23:        fmt = 3'd1;
                7'h63:        fmt = 3'd2;
                7'h6F:        fmt = 3'd3;
                7'h37, 7'h17: fmt = 3'd4;
                default: begin fmt = 3'd0; nimm = 1'b1; end
            endcase
        end
        case (fmt)
            3'd0: v = longint'($signed(ins[31:20]));
            3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd4: v = longint'($signed({ins[31:12], 12'b0}));
            3'd5: v = longint'(ins[19:15]);
            default: v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
        endcase
        if (nimm) v = 0;
        if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        imm = 64'(v);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [10];
        ops = '{7'h03, 7'h67, 7'h13, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int XL = (g == 0) ? 32 : 64;
        localparam int PD = (g == 0) ? 2 : 3;

        logic          rst_n, vin, rdy_o, vout, rdy_in, nimm;
        logic [31:0]   inst, tag, otag;
        logic [2:0]    sel, ofmt;
        logic [XL-1:0] oimm;
        exp_t          sb[$];
        bit            exact_ph = 1'b0;
        bit            fin = 1'b0;

        imm_gen_pipe #(.XLEN(XL), .PIPE_DEPTH(PD), .TAG_W(32)) dut (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_valid  (vin),
            .o_ready  (rdy_o),
            .i_inst   (inst),
            .i_immsel (sel),
            .i_tag    (tag),
            .o_valid  (vout),
            .i_ready  (rdy_in),
            .o_imm    (oimm),
            .o_fmt    (ofmt),
            .o_noimm  (nimm),
            .o_tag    (otag)
        );

        task automatic step(input bit v, input logic [31:0] in_i, input logic [2:0] s,
                            input bit r, output bit took);
            exp_t e;
            @(negedge clk);
            vin = v; inst = in_i; sel = s; tag = $urandom; rdy_in = r;
            #1;
            chk($sformatf("o_ready_d%0d", g), 64'(rdy_o), 64'((sb.size() < PD) || r));
            took = v && rdy_o;
            if (took) begin
                model(XL, in_i, s, e.imm, e.fmt, e.noimm);
                e.tag = tag; e.t_in = cyc; e.exact = exact_ph;
                sb.push_back(e);
            end
        endtask

        task automatic do_reset(input int n);
            @(negedge clk);
            rst_n = 1'b0; vin = 1'b0; rdy_in = $urandom_range(0, 1);
            #1 sb.delete();
            repeat (n - 1) @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk($sformatf("rst_valid_d%0d", g), 64'(vout), 64'd0);
            chk($sformatf("rst_imm_d%0d", g),   64'(oimm), 64'd0);
            chk($sformatf("rst_fmt_d%0d", g),   64'(ofmt), 64'd0);
            chk($sformatf("rst_noimm_d%0d", g), 64'(nimm), 64'd0);
            chk($sformatf("rst_tag_d%0d", g),   64'(otag), 64'd0);
            chk($sformatf("rst_ready_d%0d", g), 64'(rdy_o), 64'd1);
        endtask

        task automatic drain();
            bit t;
            for (int i = 0; i < 60 && sb.size() != 0; i++) step(1'b0, 32'h0, 3'd0, 1'b1, t);
            chk($sformatf("drain_timeout_d%0d", g), 64'(sb.size()), 64'd0);
        endtask

        task automatic issue(input logic [31:0] in_i, input logic [2:0] s, input bit r);
            bit t;
            t = 1'b0;
            for (int i = 0; i < 60 && !t; i++) step(1'b1, in_i, s, r, t);
            if (!t) chk($sformatf("issue_timeout_d%0d", g), 64'd0, 64'd1);
        endtask

        initial begin
            logic [31:0] dinst [9];
            logic [2:0]  dsel  [9];
            bit          t;
            dinst = '{32'hFFF00093, 32'h00112623, 32'hFFDFF06F, 32'h123452B7, 32'h3002D073,
                      32'h00309093, 32'h002081B3, 32'h800000B7, 32'h03F00013};
            dsel  = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd4, 3'd6};
            rst_n = 1'b0; vin = 1'b0; rdy_in = 1'b0; inst = '0; sel = '0; tag = '0;
            do_reset(2);

            exact_ph = 1'b1;
            for (int i = 0; i < 9; i++) issue(dinst[i], dsel[i], 1'b1);
            drain();
            exact_ph = 1'b0;

            for (int i = 0; i < 12; i++) step(1'b1, rand_inst(), 3'd7, !(i >= 3 && i <= 5), t);
            drain();

            step(1'b1, rand_inst(), 3'd7, 1'b0, t);
            step(1'b0, 32'h0, 3'd0, 1'b0, t);
            for (int i = 0; i < 4; i++) step(1'b1, rand_inst(), 3'd7, 1'b0, t);
            drain();

            for (int i = 0; i < 400; i++) begin
                logic [2:0] s;
                s = ($urandom_range(0, 1) != 0) ? 3'd7 : 3'($urandom_range(0, 7));
                if (i == 200) begin
                    while (sb.size() < 2) step(1'b1, rand_inst(), s, 1'b0, t);
                    do_reset(1);
                    exact_ph = 1'b1;
                    issue(rand_inst(), 3'd7, 1'b1);
                    drain();
                    exact_ph = 1'b0;
                end
                step($urandom_range(0, 3) != 0, rand_inst(), s, $urandom_range(0, 3) != 0, t);
            end
            drain();
            fin = 1'b1;
        end

        logic [XL-1:0] prev_imm;
        logic [31:0]   prev_tag;
        logic [2:0]    prev_fmt;
        bit            prev_stall = 1'b0;

        always @(negedge clk) begin
            exp_t e;
            int   lat;
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk($sformatf("hold_valid_d%0d", g), 64'(vout), 64'd1);
                    chk($sformatf("hold_imm_d%0d", g),   64'(oimm), 64'(prev_imm));
                    chk($sformatf("hold_tag_d%0d", g),   64'(otag), 64'(prev_tag));
                    chk($sformatf("hold_fmt_d%0d", g),   64'(ofmt), 64'(prev_fmt));
                end
                if (vout && rdy_in) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("spurious_out_d%0d", g), 64'(otag), 64'hDEAD_0000_0000_0000);
                    end else begin
                        e = sb.pop_front();
                        lat = cyc - e.t_in;
                        chk($sformatf("imm_d%0d", g),   64'(oimm), e.imm);
                        chk($sformatf("fmt_d%0d", g),   64'(ofmt), 64'(e.fmt));
                        chk($sformatf("noimm_d%0d", g), 64'(nimm), 64'(e.noimm));
                        chk($sformatf("tag_d%0d", g),   64'(otag), 64'(e.tag));
                        if (e.exact) chk($sformatf("latency_d%0d", g), 64'(lat), 64'(PD));
                        else         chk($sformatf("min_latency_d%0d", g), 64'(lat >= PD), 64'd1);
                    end
                end
                prev_stall = vout && !rdy_in;
                prev_imm   = oimm;
                prev_tag   = otag;
                prev_fmt   = ofmt;
            end
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(g_dut[0].fin && g_dut[1].fin); i++) @(posedge clk);
        if (!(g_dut[0].fin && g_dut[1].fin)) begin
            checks++;
            failures++;
            $display("FAIL run_timeout actual=unfinished required=finished");
        end
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
